// File: rtl/palette_dma.sv
// palette_dma: copies N 16-bit words from main memory into palette RAM.
// Software programs source address, destination palette index and word
// count, then arms the engine. On the next vertical-blank rising edge the
// block fetches one word at a time and writes it into the palette RAM.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   reg_we/reg_addr/reg_din register writes (0 SRC_LO, 1 SRC_HI, 2 DEST, 3 CTRL)
//   vblank_in              vertical blank from the timing generator
//   mem_req/mem_addr       source read request and word address
//   mem_ack/mem_data       read acknowledge with same-cycle data
//   pal_req/pal_busy       palette DMA request / busy
//   pal_addr/pal_we/pal_data palette write port
//   armed                  waiting for a vblank rising edge
//   done_irq               one-cycle pulse at end of transfer
module palette_dma #(
  parameter int unsigned SRC_AW = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [15:0]       reg_din,
  input  logic              vblank_in,
  output logic              mem_req,
  output logic [SRC_AW-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data,
  output logic              pal_req,
  output logic              pal_busy,
  output logic [12:0]       pal_addr,
  output logic              pal_we,
  output logic [15:0]       pal_data,
  output logic              armed,
  output logic              done_irq
);

  typedef enum logic [2:0] {StIdle, StArmed, StFetch, StWrite, StDone} state_e;

  state_e state_q, state_d;

  // Programmed configuration; never touched by a transfer so re-arming repeats it.
  logic [SRC_AW-1:0] src_cfg_q;
  logic [12:0]       dest_cfg_q;
  logic [12:0]       count_cfg_q;

  // Working copies used while the transfer runs.
  logic [SRC_AW-1:0] src_q;
  logic [12:0]       dest_q;
  logic [12:0]       rem_q;
  logic [15:0]       data_q;
  logic              vblank_q;

  logic cfg_open, ctrl_wr, vblank_rise, start;

  assign cfg_open    = (state_q == StIdle) || (state_q == StArmed);
  assign ctrl_wr     = reg_we && cfg_open && (reg_addr == 2'd3);
  assign vblank_rise = vblank_in && !vblank_q;
  // A CTRL write takes priority over a coincident vblank edge in ARMED.
  assign start       = (state_q == StArmed) && !ctrl_wr && vblank_rise;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_wr && reg_din[15]) state_d = StArmed;
      end
      StArmed: begin
        if (ctrl_wr) begin
          state_d = reg_din[15] ? StArmed : StIdle;
        end else if (vblank_rise) begin
          state_d = (count_cfg_q != 13'd0) ? StFetch : StDone;
        end
      end
      StFetch: begin
        if (mem_ack) state_d = StWrite;
      end
      StWrite: begin
        state_d = (rem_q == 13'd1) ? StDone : StFetch;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_req  = (state_q == StFetch);
    mem_addr = mem_req ? src_q : '0;
    pal_we   = (state_q == StWrite);
    pal_addr = pal_we ? dest_q : '0;
    pal_data = data_q;
    pal_busy = (state_q == StFetch) || (state_q == StWrite) || (state_q == StDone);
    pal_req  = pal_busy;
    armed    = (state_q == StArmed);
    done_irq = (state_q == StDone);
  end

  // Configuration registers: writable only while no transfer is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_cfg_q   <= '0;
      dest_cfg_q  <= '0;
      count_cfg_q <= '0;
    end else if (reg_we && cfg_open) begin
      unique case (reg_addr)
        2'd0: src_cfg_q[15:0]        <= reg_din;
        2'd1: src_cfg_q[SRC_AW-1:16] <= reg_din[SRC_AW-17:0];
        2'd2: dest_cfg_q             <= reg_din[12:0];
        2'd3: count_cfg_q            <= reg_din[12:0];
        default: ;
      endcase
    end
  end

  // Transfer datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_q    <= '0;
      dest_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      vblank_q <= 1'b0;
    end else begin
      vblank_q <= vblank_in;
      if (start) begin
        src_q  <= src_cfg_q;
        dest_q <= dest_cfg_q;
        rem_q  <= count_cfg_q;
      end
      if ((state_q == StFetch) && mem_ack) begin
        data_q <= mem_data;
      end
      if (state_q == StWrite) begin
        src_q  <= src_q + SRC_AW'(1);
        dest_q <= dest_q + 13'd1;  // wraps 8191 -> 0
        rem_q  <= rem_q - 13'd1;
      end
    end
  end

endmodule

// File: tb/tb_palette_dma.sv
module tb_palette_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [15:0] reg_din = 16'd0;
  logic        vblank_in = 1'b0;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'd0;
  logic        pal_req, pal_busy, pal_we, armed, done_irq;
  logic [12:0] pal_addr;
  logic [15:0] pal_data;

  palette_dma #(.SRC_AW(20)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .vblank_in(vblank_in),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .pal_req  (pal_req),
    .pal_busy (pal_busy),
    .pal_addr (pal_addr),
    .pal_we   (pal_we),
    .pal_data (pal_data),
    .armed    (armed),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [12:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          delay_q[$];
  int          busy_cnt, irq_cnt, wait_cnt, cur_delay, fixed_delay;
  bit          rand_delay, junk_mode;
  logic [19:0] exp_mem_addr;

  typedef struct {
    logic [19:0] src;
    logic [12:0] dest;
    int          n;
    int          delay;
    int          exp_busy;
    logic [12:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] mem_word(input logic [19:0] a);
    return 16'hA000 + {12'h000, a[3:0]} + {a[11:4], 8'h00};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; then play the memory, observe the palette port.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req) begin
      check("mem_addr", 64'(mem_addr), 64'(exp_mem_addr));
      if (wait_cnt >= cur_delay) begin
        mem_ack = 1'b1;
        mem_data = mem_word(mem_addr);
        delay_q.push_back(cur_delay);
        exp_mem_addr = exp_mem_addr + 20'd1;
        wait_cnt = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
    if (pal_we) begin
      wr_addr_q.push_back(pal_addr);
      wr_data_q.push_back(pal_data);
    end
    if (pal_busy) busy_cnt++;
    if (done_irq) irq_cnt++;
    if (junk_mode) begin
      if (pal_busy) begin
        reg_we = 1'b1;
        reg_addr = 2'($urandom);
        reg_din = 16'($urandom);
      end else begin
        reg_we = 1'b0;
      end
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
    reg_we = 1'b1;
    reg_addr = a;
    reg_din = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic start_model(input logic [19:0] src, input bit rd, input int fd);
    wr_addr_q.delete();
    wr_data_q.delete();
    delay_q.delete();
    busy_cnt = 0;
    irq_cnt = 0;
    wait_cnt = 0;
    exp_mem_addr = src;
    rand_delay = rd;
    fixed_delay = fd;
    cur_delay = rd ? int'($urandom_range(0, 3)) : fd;
  endtask

  task automatic program_and_arm(input logic [19:0] src, input logic [12:0] dest, input int n);
    reg_write(2'd0, src[15:0]);
    reg_write(2'd1, {12'hABC, src[19:16]});  // upper bits must be ignored
    reg_write(2'd2, {3'b101, dest});
    reg_write(2'd3, 16'h8000 | 16'(n));
    check("armed_after_arm", 64'(armed), 64'd1);
  endtask

  // Produce a vblank rise, run to done_irq, compare against the model.
  task automatic run_and_check(input logic [19:0] src, input logic [12:0] dest, input int n,
                               input bit junk, input string tag);
    int exp_busy;
    vblank_in = 1'b0;
    tick();
    check({tag, "_busy_before_edge"}, 64'(busy_cnt), 64'd0);
    vblank_in = 1'b1;
    tick();
    check({tag, "_busy_after_edge"}, 64'(pal_busy), 64'd1);
    if (n != 0) check({tag, "_first_req"}, 64'(mem_req), 64'd1);
    else check({tag, "_n0_irq"}, 64'(done_irq), 64'd1);
    junk_mode = junk;
    for (int c = 0; c < 400 && irq_cnt == 0; c++) tick();
    junk_mode = 1'b0;
    reg_we = 1'b0;
    tick();
    check({tag, "_idle_busy"}, 64'(pal_busy), 64'd0);
    check({tag, "_idle_armed"}, 64'(armed), 64'd0);
    vblank_in = 1'b0;
    check({tag, "_irq_count"}, 64'(irq_cnt), 64'd1);
    check({tag, "_write_count"}, 64'(wr_addr_q.size()), 64'(n));
    exp_busy = 1;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      check({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'(13'(dest + 13'(i))));
      check({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(mem_word(20'(src + 20'(i)))));
    end
    for (int i = 0; i < n && i < delay_q.size(); i++) exp_busy += delay_q[i] + 2;
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  task automatic run_transfer(input logic [19:0] src, input logic [12:0] dest, input int n,
                              input bit prog, input bit rd, input int fd, input bit junk,
                              input string tag);
    if (prog) program_and_arm(src, dest, n);
    else begin
      reg_write(2'd3, 16'h8000 | 16'(n));
      check({tag, "_armed_rearm"}, 64'(armed), 64'd1);
    end
    start_model(src, rd, fd);
    run_and_check(src, dest, n, junk, tag);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({mem_req, mem_addr, pal_req, pal_busy, pal_addr, pal_we, pal_data, armed,
                done_irq});
  endfunction

  initial begin
    logic [19:0] rs;
    logic [12:0] rdst;
    int          rn;

    vecs[0] = '{20'h01000, 13'h0100, 4, 0, 9, 13'h0103};
    vecs[1] = '{20'h01000, 13'h0100, 4, 3, 21, 13'h0103};
    vecs[2] = '{20'h00040, 13'h1FFE, 4, 0, 9, 13'h0001};
    vecs[3] = '{20'h0FFFE, 13'h0000, 3, 1, 10, 13'h0002};
    vecs[4] = '{20'hFFFFF, 13'h0A00, 2, 0, 5, 13'h0A01};
    vecs[5] = '{20'h12345, 13'h0777, 0, 0, 1, 13'h0000};

    start_model(20'h0, 1'b0, 0);
    junk_mode = 1'b0;

    // Reset state
    #3;
    check("reset_outputs_async", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    tick();
    check("reset_outputs_clocked", all_outs(), 64'd0);

    // Table-driven transfers
    foreach (vecs[i]) begin
      run_transfer(vecs[i].src, vecs[i].dest, vecs[i].n, 1'b1, 1'b0, vecs[i].delay, 1'b0,
                   $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_busy", i), 64'(busy_cnt), 64'(vecs[i].exp_busy));
      if (vecs[i].n != 0 && wr_addr_q.size() != 0)
        check($sformatf("vec%0d_tbl_last", i), 64'(wr_addr_q[wr_addr_q.size()-1]),
              64'(vecs[i].exp_last));
    end

    // Arm while vblank already high, then re-arm with N=2
    vblank_in = 1'b1;
    tick();
    tick();
    program_and_arm(20'h00200, 13'h0040, 3);
    start_model(20'h00200, 1'b0, 0);
    repeat (4) tick();
    check("vbhigh_no_busy", 64'(busy_cnt), 64'd0);
    check("vbhigh_still_armed", 64'(armed), 64'd1);
    reg_write(2'd3, 16'h8002);
    check("rearm_armed", 64'(armed), 64'd1);
    run_and_check(20'h00200, 13'h0040, 2, 1'b0, "rearm");

    // Disarm by CTRL write with bit 15 clear
    reg_write(2'd3, 16'h8005);
    check("disarm_pre", 64'(armed), 64'd1);
    reg_write(2'd3, 16'h0005);
    check("disarm_post", 64'(armed), 64'd0);
    start_model(20'h0, 1'b0, 0);
    vblank_in = 1'b0;
    tick();
    vblank_in = 1'b1;
    repeat (5) tick();
    vblank_in = 1'b0;
    check("disarm_no_busy", 64'(busy_cnt), 64'd0);

    // Reset during the second word of an 8-word transfer
    program_and_arm(20'h01000, 13'h0100, 8);
    start_model(20'h01000, 1'b0, 0);
    vblank_in = 1'b0;
    tick();
    vblank_in = 1'b1;
    for (int c = 0; c < 50 && wr_addr_q.size() < 1; c++) tick();
    tick();
    check("abort_in_fetch", 64'(mem_req), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", all_outs(), 64'd0);
    mem_ack = 1'b0;
    repeat (3) tick();
    check("abort_no_more_writes", 64'(wr_addr_q.size()), 64'd1);
    reset_n = 1'b1;
    vblank_in = 1'b0;
    start_model(20'h0, 1'b0, 0);
    tick();
    vblank_in = 1'b1;
    repeat (5) tick();
    vblank_in = 1'b0;
    check("post_reset_no_busy", 64'(busy_cnt), 64'd0);
    check("post_reset_idle", 64'(armed), 64'd0);
    // Cleared SRC/DEST: arming only N=1 must copy word 0 to index 0
    run_transfer(20'h0, 13'h0, 1, 1'b0, 1'b0, 0, 1'b0, "post_reset");

    // Randomized transfers with random ack latency and ignored writes while busy;
    // re-arming without reprogramming must repeat the same copy.
    for (int k = 0; k < 15; k++) begin
      rs = 20'($urandom);
      rdst = 13'($urandom);
      rn = int'($urandom_range(0, 6));
      run_transfer(rs, rdst, rn, 1'b1, 1'b1, 0, 1'b1, $sformatf("rnd%0d", k));
      run_transfer(rs, rdst, rn, 1'b0, 1'b1, 0, 1'b0, $sformatf("rep%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
